vending_machine: RTL and testbench

VENDING_MACHINE -- requirements
Module: vending_machine

---
 rtl/vending_machine.sv | 144 ++++++++++++++
 tb/tb_vending_machine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// rtl/vending_machine.sv - coin-operated vending controller with edge-detected inputs and timed change return
module vending_machine #(
    parameter int PRICE0      = 400,
    parameter int PRICE1      = 500,
    parameter int PRICE2      = 1000,
    parameter int PRICE3      = 2000,
    parameter int WAIT_TIME   = 100,
    parameter int MAX_BALANCE = 10000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] i_input_coin,
    input  logic [3:0] i_select_item,
    input  logic       i_trigger_return,
    output logic [3:0] o_available_item,
    output logic [3:0] o_output_item,
    output logic [2:0] o_return_coin
);

    typedef enum logic {
        ST_VEND,
        ST_RETURN
    } state_t;

    // Idle counter saturates at WAIT_TIME so it never wraps while the balance is zero.
    localparam int IDLE_W = (WAIT_TIME < 2) ? 1 : $clog2(WAIT_TIME + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(WAIT_TIME);
    localparam logic [16:0] MAX_BAL = 17'(MAX_BALANCE);

    state_t            state, state_next;
    logic [15:0]       balance, bal_next;
    logic [IDLE_W-1:0] idle, idle_next;
    logic [2:0]        coin_q, coin_prev;
    logic [3:0]        sel_q, sel_prev;
    logic              trig_q;
    logic [3:0]        item_next;
    logic [2:0]        ret_next;

    logic [2:0]        coin_rise;
    logic [3:0]        sel_rise;
    logic [16:0]       coin_sum;
    logic [15:0]       disp_bal;
    logic              found;
    logic              credit;

    function automatic logic [15:0] price_of(input int idx);
        case (idx)
            0:       price_of = 16'(PRICE0);
            1:       price_of = 16'(PRICE1);
            2:       price_of = 16'(PRICE2);
            default: price_of = 16'(PRICE3);
        endcase
    endfunction

    assign coin_rise = coin_q & ~coin_prev;
    assign sel_rise  = sel_q & ~sel_prev;

    // Affordability flags come straight from the balance register and are hidden while refunding.
    assign o_available_item = (state == ST_VEND) ?
        {balance >= price_of(3), balance >= price_of(2), balance >= price_of(1), balance >= price_of(0)} :
        4'b0000;

    // State, balance, input pipeline and output pulse registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state         <= ST_VEND;
            balance       <= 16'd0;
            idle          <= '0;
            coin_q        <= 3'b000;
            coin_prev     <= 3'b000;
            sel_q         <= 4'b0000;
            sel_prev      <= 4'b0000;
            trig_q        <= 1'b0;
            o_output_item <= 4'b0000;
            o_return_coin <= 3'b000;
        end else begin
            state         <= state_next;
            balance       <= bal_next;
            idle          <= idle_next;
            coin_q        <= i_input_coin;
            coin_prev     <= coin_q;
            sel_q         <= i_select_item;
            sel_prev      <= sel_q;
            trig_q        <= i_trigger_return;
            o_output_item <= item_next;
            o_return_coin <= ret_next;
        end
    end

    // Next-state logic: dispense against the pre-credit balance, then credit coins, then decide on refund.
    always_comb begin
        state_next = state;
        bal_next   = balance;
        idle_next  = idle;
        item_next  = 4'b0000;
        ret_next   = 3'b000;
        found      = 1'b0;
        disp_bal   = balance;
        credit     = 1'b0;
        coin_sum   = (coin_rise[0] ? 17'd100 : 17'd0) +
                     (coin_rise[1] ? 17'd500 : 17'd0) +
                     (coin_rise[2] ? 17'd1000 : 17'd0);

        case (state)
            ST_VEND: begin
                for (int i = 0; i < 4; i++) begin
                    if (!found && sel_rise[i] && (price_of(i) <= balance)) begin
                        found        = 1'b1;
                        item_next[i] = 1'b1;
                        disp_bal     = balance - price_of(i);
                    end
                end
                credit   = (coin_sum != 17'd0) && (({1'b0, disp_bal} + coin_sum) <= MAX_BAL);
                bal_next = credit ? (disp_bal + coin_sum[15:0]) : disp_bal;
                if (credit || found) begin
                    idle_next = '0;
                end else if (idle != IDLE_MAX) begin
                    idle_next = idle + 1'b1;
                end
                if ((balance != 16'd0) && (trig_q || (idle == IDLE_MAX))) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (balance >= 16'd1000) begin
                    ret_next = 3'b100;
                    bal_next = balance - 16'd1000;
                end else if (balance >= 16'd500) begin
                    ret_next = 3'b010;
                    bal_next = balance - 16'd500;
                end else if (balance >= 16'd100) begin
                    ret_next = 3'b001;
                    bal_next = balance - 16'd100;
                end
                if (bal_next == 16'd0) begin
                    state_next = ST_VEND;
                    idle_next  = '0;
                end
            end
            default: state_next = ST_VEND;
        endcase
    end

endmodule

// File: tb/tb_vending_machine.sv
// tb/tb_vending_machine.sv - table-driven and sequence checks for vending_machine
module tb_vending_machine;

    logic       clk;
    logic       reset_n;
    logic [2:0] i_input_coin;
    logic [3:0] i_select_item;
    logic       i_trigger_return;
    logic [3:0] o_available_item;
    logic [3:0] o_output_item;
    logic [2:0] o_return_coin;

    int tests;
    int fails;

    localparam int WAIT = 100;

    vending_machine dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_input_coin    (i_input_coin),
        .i_select_item   (i_select_item),
        .i_trigger_return(i_trigger_return),
        .o_available_item(o_available_item),
        .o_output_item   (o_output_item),
        .o_return_coin   (o_return_coin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [2:0] coin;
        logic [3:0] sel;
        int         hold;
        logic [3:0] avail;
        int         bal;
        logic [3:0] item;
        int         npulse;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] coin, input logic [3:0] sel, input int hold,
                       input logic [3:0] avail, input int bal, input logic [3:0] item, input int npulse);
        vec_t v;
        v.rst = rst; v.coin = coin; v.sel = sel; v.hold = hold;
        v.avail = avail; v.bal = bal; v.item = item; v.npulse = npulse;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        step();
    endtask

    task automatic apply(input logic [2:0] coin, input logic [3:0] sel, input int hold,
                         output logic [3:0] seen, output int npulse);
        seen   = 4'b0000;
        npulse = 0;
        i_input_coin  = coin;
        i_select_item = sel;
        for (int k = 0; k < hold + 3; k++) begin
            if (k == hold) begin
                i_input_coin  = 3'b000;
                i_select_item = 4'b0000;
            end
            step();
            if (o_output_item != 4'b0000) begin
                seen = seen | o_output_item;
                npulse++;
            end
        end
    endtask

    task automatic insert(input logic [2:0] coin);
        logic [3:0] s;
        int n;
        apply(coin, 4'b0000, 1, s, n);
    endtask

    initial begin
        logic [3:0] seen;
        int         np;
        logic [2:0] rq[$];
        int         rc[$];
        int         sum;
        int         coin_timer;
        logic [2:0] exp_to[6];
        logic [2:0] exp_tr[8];

        tests = 0;
        fails = 0;
        reset_n          = 1'b1;
        i_input_coin     = 3'b000;
        i_select_item    = 4'b0000;
        i_trigger_return = 1'b0;

        // Coin crediting and availability flags.
        add(1, 3'b001, 4'b0000, 1, 4'b0000, 100, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0000, 200, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0000, 300, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0001, 400, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0011, 500, 4'b0000, 0);
        add(1, 3'b010, 4'b0000, 1, 4'b0011, 500, 4'b0000, 0);
        add(0, 3'b010, 4'b0000, 1, 4'b0111, 1000, 4'b0000, 0);
        add(0, 3'b010, 4'b0000, 1, 4'b0111, 1500, 4'b0000, 0);
        add(0, 3'b010, 4'b0000, 1, 4'b1111, 2000, 4'b0000, 0);
        add(1, 3'b100, 4'b0000, 1, 4'b0111, 1000, 4'b0000, 0);
        add(0, 3'b100, 4'b0000, 1, 4'b1111, 2000, 4'b0000, 0);
        // Dispense item 0 from 3000 down to 200, then one unaffordable request.
        add(0, 3'b100, 4'b0000, 1, 4'b1111, 3000, 4'b0000, 0);
        add(0, 3'b000, 4'b0001, 1, 4'b1111, 2600, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b1111, 2200, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0111, 1800, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0111, 1400, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0111, 1000, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0011, 600, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0000, 200, 4'b0001, 1);
        add(0, 3'b000, 4'b0001, 1, 4'b0000, 200, 4'b0000, 0);
        // Held select acts once.
        add(1, 3'b100, 4'b0000, 1, 4'b0111, 1000, 4'b0000, 0);
        add(0, 3'b100, 4'b0000, 1, 4'b1111, 2000, 4'b0000, 0);
        add(0, 3'b100, 4'b0000, 1, 4'b1111, 3000, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b1111, 3100, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b1111, 3200, 4'b0000, 0);
        add(0, 3'b000, 4'b0010, 3, 4'b1111, 2700, 4'b0010, 1);
        // Insufficient balance, then lowest affordable of several requests.
        add(1, 3'b001, 4'b0000, 1, 4'b0000, 100, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0000, 200, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0000, 300, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b0001, 400, 4'b0000, 0);
        add(0, 3'b000, 4'b1000, 1, 4'b0001, 400, 4'b0000, 0);
        add(0, 3'b000, 4'b1111, 1, 4'b0000, 0, 4'b0001, 1);
        add(0, 3'b010, 4'b0000, 1, 4'b0011, 500, 4'b0000, 0);
        add(0, 3'b000, 4'b1010, 1, 4'b0000, 0, 4'b0010, 1);
        // Simultaneous coins sum; ceiling rejects overflow.
        add(1, 3'b111, 4'b0000, 1, 4'b0111, 1600, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 3200, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 4800, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 6400, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 8000, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 9600, 4'b0000, 0);
        add(0, 3'b111, 4'b0000, 1, 4'b1111, 9600, 4'b0000, 0);
        add(0, 3'b010, 4'b0000, 1, 4'b1111, 9600, 4'b0000, 0);
        add(0, 3'b001, 4'b0000, 1, 4'b1111, 9700, 4'b0000, 0);

        // Reset state.
        step();
        check("reset avail", int'(o_available_item), 0);
        check("reset item", int'(o_output_item), 0);
        check("reset ret", int'(o_return_coin), 0);
        check("reset bal", int'(dut.balance), 0);
        reset_n = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].coin, vecs[i].sel, vecs[i].hold, seen, np);
            check($sformatf("v%0d avail", i), int'(o_available_item), int'(vecs[i].avail));
            check($sformatf("v%0d bal", i), int'(dut.balance), vecs[i].bal);
            check($sformatf("v%0d item", i), int'(seen), int'(vecs[i].item));
            check($sformatf("v%0d npulse", i), np, vecs[i].npulse);
        end

        // Timeout refund of 2800.
        exp_to = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
        do_reset();
        insert(3'b100); insert(3'b100); insert(3'b010);
        insert(3'b001); insert(3'b001); insert(3'b001);
        check("to bal before", int'(dut.balance), 2800);
        rq.delete(); rc.delete();
        for (int c = 0; c < WAIT + 40; c++) begin
            step();
            if (o_return_coin != 3'b000) begin
                rq.push_back(o_return_coin);
                rc.push_back(c);
                check($sformatf("to avail during return %0d", c), int'(o_available_item), 0);
            end
        end
        check("to npulse", rq.size(), 6);
        if (rq.size() == 6) begin
            check("to first cycle early", int'(rc[0] >= WAIT - 3), 1);
            check("to first cycle late", int'(rc[0] <= WAIT + 3), 1);
            for (int k = 0; k < 6; k++) begin
                check($sformatf("to coin %0d", k), int'(rq[k]), int'(exp_to[k]));
                check($sformatf("to consecutive %0d", k), rc[k], rc[0] + k);
            end
        end
        check("to bal after", int'(dut.balance), 0);

        // Trigger refund of 4800 with coins pushed during the refund.
        exp_tr = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
        do_reset();
        insert(3'b100); insert(3'b100); insert(3'b100); insert(3'b100);
        insert(3'b010); insert(3'b001); insert(3'b001); insert(3'b001);
        check("tr bal before", int'(dut.balance), 4800);
        i_trigger_return = 1'b1;
        rq.delete(); rc.delete();
        coin_timer = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (coin_timer > 0) begin
                coin_timer--;
                if (coin_timer == 0) i_input_coin = 3'b000;
            end
            if (o_return_coin != 3'b000) begin
                if (rq.size() == 0) begin
                    i_input_coin = 3'b111;
                    coin_timer   = 2;
                end
                rq.push_back(o_return_coin);
                rc.push_back(c);
            end
        end
        check("tr npulse", rq.size(), 8);
        sum = 0;
        foreach (rq[k]) sum += (rq[k] == 3'b100) ? 1000 : (rq[k] == 3'b010) ? 500 : (rq[k] == 3'b001) ? 100 : 0;
        check("tr sum", sum, 4800);
        if (rq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("tr coin %0d", k), int'(rq[k]), int'(exp_tr[k]));
                check($sformatf("tr consecutive %0d", k), rc[k], rc[0] + k);
            end
        end
        check("tr bal after", int'(dut.balance), 0);

        // Trigger still held: a fresh 100 is refunded once and nothing more.
        i_input_coin = 3'b001;
        step();
        i_input_coin = 3'b000;
        rq.delete();
        for (int c = 0; c < 15; c++) begin
            step();
            if (o_return_coin != 3'b000) rq.push_back(o_return_coin);
        end
        check("held trig npulse", rq.size(), 1);
        if (rq.size() == 1) check("held trig coin", int'(rq[0]), 1);
        check("held trig bal", int'(dut.balance), 0);
        i_trigger_return = 1'b0;

        // Reset in the middle of a refund discards the rest.
        do_reset();
        insert(3'b100); insert(3'b100); insert(3'b100);
        i_trigger_return = 1'b1;
        np = 0;
        for (int c = 0; c < 20 && np == 0; c++) begin
            step();
            if (o_return_coin != 3'b000) np = 1;
        end
        check("mid rst got first pulse", np, 1);
        #2 reset_n = 1'b1;
        #1;
        check("mid rst bal", int'(dut.balance), 0);
        check("mid rst ret", int'(o_return_coin), 0);
        check("mid rst avail", int'(o_available_item), 0);
        i_trigger_return = 1'b0;
        step();
        reset_n = 1'b0;
        np = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_return_coin != 3'b000) np++;
        end
        check("mid rst no pulses", np, 0);
        check("mid rst bal after", int'(dut.balance), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
